// File: rtl/cyusb_frame_scheduler.sv
// Ping-pong frame scheduler: writes ADC samples into one of two FIFO banks while USB drains the other.
// Latency: a valid sample reaches fifo_wr_en/fifo_data one clock later; bank swap is decided in one SWAP clock.
// Backpressure: none on samples; if the read bank is still occupied at frame end the frame is dropped and counted.
//
// Ports:
//   clk_48M, rst_n              - clock and asynchronous active-low reset
//   en                          - scheduler enable; low forces IDLE on the next clock
//   frame_start                 - chirp start pulse, honoured only in ARMED
//   sample_valid, sample_data   - ADC sample stream
//   used_0, used_1              - word counts of FIFO bank 0 / bank 1
//   fifo_addr                   - bank currently written (the other bank is read by USB)
//   fifo_rst                    - reset pulse for the write bank
//   fifo_wr_en, fifo_data       - write strobe and data
//   fifo_data_prepare_ok        - a complete frame is waiting in the read bank
//   frame_cnt, drop_cnt, busy   - frames handed over (wraps), frames dropped (saturates), not-IDLE flag
module cyusb_frame_scheduler #(
    parameter int FRAME_WORDS = 1024,
    parameter int RST_CYCLES  = 8,
    parameter int WAIT_CYCLES = 16,
    parameter int USED_W      = 11
) (
    input  logic              clk_48M,
    input  logic              rst_n,
    input  logic              en,
    input  logic              frame_start,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    input  logic [USED_W-1:0] used_0,
    input  logic [USED_W-1:0] used_1,
    output logic              fifo_addr,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_data,
    output logic              fifo_data_prepare_ok,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int TMAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int TC_W = $clog2(TMAX + 1);
    localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [TC_W-1:0] RST_LAST  = TC_W'(RST_CYCLES - 1);
    localparam logic [TC_W-1:0] WAIT_LAST = TC_W'(WAIT_CYCLES - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_BANK,
        RST_WAIT,
        ARMED,
        FILL,
        SWAP
    } state_t;

    state_t            state;
    logic [TC_W-1:0]   tmr;
    logic [WC_W-1:0]   word_cnt;   // index of the next word to be written

    // The read bank is whichever bank is not being written.
    logic [USED_W-1:0] rd_used;
    logic              rd_draining;

    assign rd_used     = fifo_addr ? used_0 : used_1;
    assign rd_draining = (rd_used != '0) && (32'(rd_used) < 32'(FRAME_WORDS));

    always_ff @(posedge clk_48M or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            tmr                  <= '0;
            word_cnt             <= '0;
            fifo_addr            <= 1'b0;
            fifo_rst             <= 1'b0;
            fifo_wr_en           <= 1'b0;
            fifo_data            <= '0;
            fifo_data_prepare_ok <= 1'b0;
            frame_cnt            <= '0;
            drop_cnt             <= '0;
            busy                 <= 1'b0;
        end else if (!en) begin
            // Abort whatever is in flight; bank select and statistics survive.
            state                <= IDLE;
            tmr                  <= '0;
            word_cnt             <= '0;
            fifo_rst             <= 1'b0;
            fifo_wr_en           <= 1'b0;
            fifo_data_prepare_ok <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;

            // USB has started pulling the frame out. The SWAP branch below
            // assigns later, so a set always wins over a clear in one clock.
            if (fifo_data_prepare_ok && rd_draining) begin
                fifo_data_prepare_ok <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state    <= RST_BANK;
                    tmr      <= '0;
                    fifo_rst <= 1'b1;
                    busy     <= 1'b1;
                end

                RST_BANK: begin
                    if (tmr == RST_LAST) begin
                        state    <= RST_WAIT;
                        tmr      <= '0;
                        fifo_rst <= 1'b0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                // FIFO reset-busy recovery: no writes allowed yet.
                RST_WAIT: begin
                    if (tmr == WAIT_LAST) begin
                        state <= ARMED;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                ARMED: begin
                    if (frame_start) begin
                        if (sample_valid) begin
                            // Sample coincident with the start pulse is word 0.
                            fifo_wr_en <= 1'b1;
                            fifo_data  <= sample_data;
                            if (FRAME_WORDS == 1) begin
                                state    <= SWAP;
                                word_cnt <= '0;
                            end else begin
                                state    <= FILL;
                                word_cnt <= WC_W'(1);
                            end
                        end else begin
                            state    <= FILL;
                            word_cnt <= '0;
                        end
                    end
                end

                FILL: begin
                    if (sample_valid) begin
                        fifo_wr_en <= 1'b1;
                        fifo_data  <= sample_data;
                        if (word_cnt == WORD_LAST) begin
                            state    <= SWAP;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end

                SWAP: begin
                    if (rd_used == '0) begin
                        fifo_addr            <= ~fifo_addr;
                        fifo_data_prepare_ok <= 1'b1;
                        frame_cnt            <= frame_cnt + 16'd1;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                    // Either way the write bank is reset: a dropped frame is
                    // discarded, a handed-over bank becomes the new read bank.
                    state    <= RST_BANK;
                    tmr      <= '0;
                    fifo_rst <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    fifo_rst <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
